// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/consumer and the pwm_capture block.
// master drives the PWM pin and reads results; slave is the capture block.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] imp_width;
  logic [CNT_W-1:0] period;
  logic             meas_valid;
  logic             overflow;
  logic             timeout;

  modport master (
    output pwm_in,
    input  imp_width,
    input  period,
    input  meas_valid,
    input  overflow,
    input  timeout
  );

  modport slave (
    input  pwm_in,
    output imp_width,
    output period,
    output meas_valid,
    output overflow,
    output timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in clk cycles,
// publishing on each rising edge and flagging dead or over-long inputs.
//
// state | meaning
// IDLE  | no reference edge yet (after reset or timeout), wait for rise
// HIGH  | synchronised input high, counting high time
// LOW   | synchronised input low, next rise completes a cycle
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_capture_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic pwm_m_q, pwm_s_q, pwm_d_q;
  logic rise, fall, any_edge, tmo_hit;
  logic counting, publish, hi_latch;

  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic             sat_q, sat_d;

  logic [CNT_W-1:0] imp_width_q, imp_width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;

  // Both edges see the same two-flop latency, so measured widths are exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_m_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
    end else begin
      pwm_m_q <= bus.pwm_in;
      pwm_s_q <= pwm_m_q;
      pwm_d_q <= pwm_s_q;
    end
  end

  assign rise     = pwm_s_q & ~pwm_d_q;
  assign fall     = ~pwm_s_q & pwm_d_q;
  assign any_edge = rise | fall;

  // Fires only on the cycle q_cnt steps onto MAX, so a quiet input strobes once.
  assign tmo_hit  = ~any_edge && (q_cnt_q == (MAX - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rise) state_d = ST_HIGH;
        ST_HIGH: if (fall) state_d = ST_LOW;
        ST_LOW:  if (rise) state_d = ST_HIGH;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    counting = 1'b0;
    publish  = 1'b0;
    hi_latch = 1'b0;
    case (state_q)
      ST_HIGH: begin
        counting = 1'b1;
        hi_latch = fall;
      end
      ST_LOW: begin
        counting = 1'b1;
        publish  = rise;
      end
      default: begin
        counting = 1'b0;
      end
    endcase
  end

  always_comb begin
    per_cnt_d = per_cnt_q;
    sat_d     = sat_q;
    if (rise) begin
      per_cnt_d = ONE;
      sat_d     = 1'b0;
    end else if (counting) begin
      if (per_cnt_q == MAX) begin
        sat_d = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + ONE;
      end
    end

    hi_cnt_d = hi_latch ? per_cnt_q : hi_cnt_q;

    if (any_edge) begin
      q_cnt_d = ZERO;
    end else if (q_cnt_q == MAX) begin
      q_cnt_d = MAX;
    end else begin
      q_cnt_d = q_cnt_q + ONE;
    end
  end

  always_comb begin
    imp_width_d  = imp_width_q;
    period_d     = period_q;
    overflow_d   = overflow_q;
    timeout_d    = timeout_q;
    meas_valid_d = 1'b0;
    if (publish) begin
      imp_width_d  = hi_cnt_q;
      period_d     = per_cnt_q;
      overflow_d   = sat_q;
      timeout_d    = 1'b0;
      meas_valid_d = 1'b1;
    end else if (tmo_hit) begin
      // A stuck-high input reports full-scale, a stuck-low one reports zero.
      imp_width_d  = pwm_s_q ? MAX : ZERO;
      period_d     = pwm_s_q ? MAX : ZERO;
      overflow_d   = 1'b0;
      timeout_d    = 1'b1;
      meas_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt_q    <= ZERO;
      hi_cnt_q     <= ZERO;
      q_cnt_q      <= ZERO;
      sat_q        <= 1'b0;
      imp_width_q  <= ZERO;
      period_q     <= ZERO;
      meas_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      q_cnt_q      <= q_cnt_d;
      sat_q        <= sat_d;
      imp_width_q  <= imp_width_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.imp_width  = imp_width_q;
  assign bus.period     = period_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a 16-bit instance for steady, sweep, timeout
// and reset cases, and an 8-bit instance for saturation and dead-high cases.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [15:0] w;
    logic [15:0] p;
    logic        ovf;
    logic        tmo;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];

  pwm_capture_if #(.CNT_W(16)) ifa ();
  pwm_capture_if #(.CNT_W(8))  ifb ();

  pwm_capture #(.CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  pwm_capture #(.CNT_W(8))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe loggers: record cycle number and published values of every strobe.
  always @(posedge clk) begin
    rec_t r;
    #1;
    if (ifa.meas_valid === 1'b1) begin
      r.cyc = cyc;
      r.w   = ifa.imp_width;
      r.p   = ifa.period;
      r.ovf = ifa.overflow;
      r.tmo = ifa.timeout;
      qa.push_back(r);
    end
    if (ifb.meas_valid === 1'b1) begin
      r.cyc = cyc;
      r.w   = {8'h00, ifb.imp_width};
      r.p   = {8'h00, ifb.period};
      r.ovf = ifb.overflow;
      r.tmo = ifb.timeout;
      qb.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rec(input string tag, input rec_t r, input int unsigned c,
                         input int unsigned w, input int unsigned p,
                         input logic ovf, input logic tmo);
    chk({tag, "_cyc"}, r.cyc, c);
    chk({tag, "_width"}, {16'h0, r.w}, w);
    chk({tag, "_period"}, {16'h0, r.p}, p);
    chk({tag, "_ovf"}, {31'h0, r.ovf}, {31'h0, ovf});
    chk({tag, "_tmo"}, {31'h0, r.tmo}, {31'h0, tmo});
  endtask

  // Advance n clock edges and land 2 time units after the last one.
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic pulse_a(input int hi, input int per);
    ifa.pwm_in = 1'b1;
    run(hi);
    ifa.pwm_in = 1'b0;
    run(per - hi);
  endtask

  task automatic pulse_b(input int hi, input int per);
    ifb.pwm_in = 1'b1;
    run(hi);
    ifb.pwm_in = 1'b0;
    run(per - hi);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_a_width"}, {16'h0, ifa.imp_width}, 0);
    chk({tag, "_a_period"}, {16'h0, ifa.period}, 0);
    chk({tag, "_a_valid"}, {31'h0, ifa.meas_valid}, 0);
    chk({tag, "_a_ovf"}, {31'h0, ifa.overflow}, 0);
    chk({tag, "_a_tmo"}, {31'h0, ifa.timeout}, 0);
  endtask

  initial begin
    int unsigned r0, s0, f0, h0, b0;
    int widths[4];

    rst_n      = 1'b0;
    ifa.pwm_in = 1'b0;
    ifb.pwm_in = 1'b0;
    run(3);
    chk_outs_zero("reset");
    chk("reset_b_width", {24'h0, ifb.imp_width}, 0);
    chk("reset_b_valid", {31'h0, ifb.meas_valid}, 0);
    rst_n = 1'b1;
    run(2);

    // Steady 256/64: first strobe only after the second rise, then every 256.
    qa.delete();
    r0 = cyc;
    for (int k = 0; k < 5; k++) pulse_a(64, 256);
    chk("steady_count", qa.size(), 4);
    for (int k = 0; k < 4 && k < qa.size(); k++)
      chk_rec("steady", qa[k], r0 + 256 * (k + 1) + 3, 64, 256, 1'b0, 1'b0);

    // High-time sweep; each value appears one period after it is driven.
    qa.delete();
    s0 = cyc;
    widths = '{64, 1, 128, 255};
    pulse_a(1, 256);
    pulse_a(128, 256);
    pulse_a(255, 256);
    pulse_a(64, 256);
    chk("sweep_count", qa.size(), 4);
    for (int k = 0; k < 4 && k < qa.size(); k++)
      chk_rec("sweep", qa[k], s0 + 256 * k + 3, widths[k], 256, 1'b0, 1'b0);

    // Dead-low input: last fall was driven 64 cycles into the final pulse.
    qa.delete();
    f0 = s0 + 768 + 64;
    run(f0 + 65535 + 3 + 20 - cyc);
    chk("dead_low_count", qa.size(), 1);
    if (qa.size() > 0) chk_rec("dead_low", qa[0], f0 + 65535 + 3, 0, 0, 1'b0, 1'b1);
    chk("dead_low_tmo_level", {31'h0, ifa.timeout}, 1);

    // Recovery: timeout holds through the first rise, clears with the second.
    qa.delete();
    r0 = cyc;
    pulse_a(64, 256);
    chk("recover_no_strobe", qa.size(), 0);
    chk("recover_tmo_held", {31'h0, ifa.timeout}, 1);
    pulse_a(64, 256);
    chk("recover_count", qa.size(), 1);
    if (qa.size() > 0) chk_rec("recover", qa[0], r0 + 256 + 3, 64, 256, 1'b0, 1'b0);
    chk("recover_tmo_level", {31'h0, ifa.timeout}, 0);

    // Reset in the middle of a high phase.
    ifa.pwm_in = 1'b1;
    run(20);
    rst_n = 1'b0;
    #1;
    chk_outs_zero("async_rst");
    run(3);
    chk_outs_zero("held_rst");
    rst_n = 1'b1;
    ifa.pwm_in = 1'b0;
    run(10);
    qa.delete();
    r0 = cyc;
    for (int k = 0; k < 3; k++) pulse_a(64, 256);
    chk("post_rst_count", qa.size(), 2);
    for (int k = 0; k < 2 && k < qa.size(); k++)
      chk_rec("post_rst", qa[k], r0 + 256 * (k + 1) + 3, 64, 256, 1'b0, 1'b0);

    // 8-bit instance: high 100 / low 200 saturates the period counter.
    qb.delete();
    b0 = cyc;
    for (int k = 0; k < 4; k++) pulse_b(100, 300);
    chk("sat_count", qb.size(), 3);
    for (int k = 0; k < 3 && k < qb.size(); k++)
      chk_rec("sat", qb[k], b0 + 300 * (k + 1) + 3, 100, 255, 1'b1, 1'b0);

    // Dead-high on the 8-bit instance: last saturated result, then full-scale timeout.
    qb.delete();
    h0 = cyc;
    ifb.pwm_in = 1'b1;
    run(600);
    chk("dead_high_count", qb.size(), 2);
    if (qb.size() > 0) chk_rec("dead_high_pub", qb[0], h0 + 3, 100, 255, 1'b1, 1'b0);
    if (qb.size() > 1) chk_rec("dead_high", qb[1], h0 + 255 + 3, 255, 255, 1'b0, 1'b1);

    // Falling back to low from idle gives one zero-valued timeout strobe.
    qb.delete();
    f0 = cyc;
    ifb.pwm_in = 1'b0;
    run(600);
    chk("dead_low_b_count", qb.size(), 1);
    if (qb.size() > 0) chk_rec("dead_low_b", qb[0], f0 + 255 + 3, 0, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
